// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC select encoding,
// instruction size and default vectors.
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_J,
        SEL_JR,
        SEL_RAS,
        SEL_EXC
    } nextSel_e;

    localparam int          INSTR_BYTES          = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack. topPtr always indexes the most recent
// entry; a push onto a full stack silently overwrites the oldest entry.
module ras_stack
    import pc_pkg::*;
#(
    parameter int W         = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] pushData,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  entries [RAS_DEPTH];
    logic [PW-1:0] topPtr;
    logic [PW-1:0] nextPtr;
    logic [CW-1:0] count;
    logic          popValid;

    // Status flags and top-of-stack view; an empty stack reads as zero.
    always_comb begin
        empty    = (count == '0);
        full     = (count == CW'(RAS_DEPTH));
        popValid = pop && !empty;
        nextPtr  = topPtr + PW'(1);
        top      = empty ? '0 : entries[topPtr];
    end

    // Push/pop bookkeeping; a simultaneous push and valid pop replaces the top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                entries[i] <= '0;
            end
            topPtr <= '0;
            count  <= '0;
        end else if (push && popValid) begin
            entries[topPtr] <= pushData;
        end else if (push) begin
            entries[nextPtr] <= pushData;
            topPtr           <= nextPtr;
            if (!full) begin
                count <= count + CW'(1);
            end
        end else if (popValid) begin
            topPtr <= topPtr - PW'(1);
            count  <= count - CW'(1);
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: selects the next fetch address (sequential, branch,
// jump, jump-register or return prediction) and keeps a return-address stack.
// Optional misaligned-target trap is enabled with the PC_MISALIGN_EN macro.
module pc_unit
    import pc_pkg::*;
#(
    parameter int          W            = 32,
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int          RAS_DEPTH    = 4
`ifdef PC_MISALIGN_EN
    ,
    parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR
`endif
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         SaltoCond,
    input  logic         branch_ne,
    input  logic         oZero,
    input  logic [W-1:0] extSigno,
    input  logic         jump,
    input  logic [25:0]  jump_target,
    input  logic         jump_reg,
    input  logic [W-1:0] reg_target,
    input  logic         call,
    input  logic         ret,
    output logic [W-1:0] direinstrux,
    output logic [W-1:0] pc_plus4,
    output logic [W-1:0] ras_top,
    output logic         ras_empty,
    output logic         ras_full
`ifdef PC_MISALIGN_EN
    ,
    output logic         misalign
`endif
);

    localparam logic [W-1:0] RESET_PC = W'(RESET_VECTOR);
`ifdef PC_MISALIGN_EN
    localparam logic [W-1:0] EXC_PC   = W'(EXC_VECTOR);
`endif

    nextSel_e     sel;
    logic [W-1:0] branchTarget;
    logic [W-1:0] jumpAddr;
    logic [W-1:0] nextPc;
    logic         taken;
    logic         misalignNext;
    logic         rasPush;
    logic         rasPop;

    // Candidate targets, all derived from the current PC.
    always_comb begin
        pc_plus4     = direinstrux + W'(INSTR_BYTES);
        branchTarget = pc_plus4 + (extSigno << 2);
        jumpAddr     = {pc_plus4[W-1:28], jump_target, 2'b00};
        taken        = SaltoCond && (oZero ^ branch_ne);
    end

    // Next-PC priority: jump_reg over jump over taken branch over sequential.
    always_comb begin
        sel          = SEL_SEQ;
        nextPc       = pc_plus4;
        misalignNext = 1'b0;
        if (jump_reg) begin
            sel = (ret && !ras_empty) ? SEL_RAS : SEL_JR;
        end else if (jump) begin
            sel = SEL_J;
        end else if (taken) begin
            sel = SEL_BR;
        end
`ifdef PC_MISALIGN_EN
        case (sel)
            SEL_BR:  misalignNext = (branchTarget[1:0] != 2'b00);
            SEL_J:   misalignNext = 1'b0;
            SEL_JR:  misalignNext = (reg_target[1:0] != 2'b00);
            SEL_RAS: misalignNext = (ras_top[1:0] != 2'b00);
            default: misalignNext = (pc_plus4[1:0] != 2'b00);
        endcase
        if (misalignNext) begin
            sel = SEL_EXC;
        end
`endif
        case (sel)
            SEL_BR:  nextPc = branchTarget;
            SEL_J:   nextPc = jumpAddr;
            SEL_JR:  nextPc = reg_target;
            SEL_RAS: nextPc = ras_top;
`ifdef PC_MISALIGN_EN
            SEL_EXC: nextPc = EXC_PC;
`endif
            default: nextPc = pc_plus4;
        endcase
    end

    // Stall freezes both the PC and the return-address stack.
    always_comb begin
        rasPush = call && !stall;
        rasPop  = ret && jump_reg && !stall;
    end

    // PC register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            direinstrux <= RESET_PC;
        end else if (!stall) begin
            direinstrux <= nextPc;
        end
    end

`ifdef PC_MISALIGN_EN
    // One-cycle flag marking that the PC was redirected to the trap vector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign <= 1'b0;
        end else begin
            misalign <= misalignNext && !stall;
        end
    end
`endif

    ras_stack #(
        .W         (W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .reset    (reset),
        .push     (rasPush),
        .pop      (rasPop),
        .pushData (pc_plus4),
        .top      (ras_top),
        .empty    (ras_empty),
        .full     (ras_full)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with W=32, RAS_DEPTH=4, reset vector 0.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        SaltoCond;
    logic        branch_ne;
    logic        oZero;
    logic [31:0] extSigno;
    logic        jump;
    logic [25:0] jump_target;
    logic        jump_reg;
    logic [31:0] reg_target;
    logic        call;
    logic        ret;
    logic [31:0] direinstrux;
    logic [31:0] pc_plus4;
    logic [31:0] ras_top;
    logic        ras_empty;
    logic        ras_full;
`ifdef PC_MISALIGN_EN
    logic        misalign;
`endif

    int nTests = 0;
    int nFail  = 0;

    pc_unit #(
        .W            (32),
        .RESET_VECTOR (32'h0000_0000),
        .RAS_DEPTH    (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .SaltoCond   (SaltoCond),
        .branch_ne   (branch_ne),
        .oZero       (oZero),
        .extSigno    (extSigno),
        .jump        (jump),
        .jump_target (jump_target),
        .jump_reg    (jump_reg),
        .reg_target  (reg_target),
        .call        (call),
        .ret         (ret),
        .direinstrux (direinstrux),
        .pc_plus4    (pc_plus4),
        .ras_top     (ras_top),
        .ras_empty   (ras_empty),
        .ras_full    (ras_full)
`ifdef PC_MISALIGN_EN
        ,
        .misalign    (misalign)
`endif
    );

    always #5 clk = ~clk;

    task automatic clearIn();
        stall       = 1'b0;
        SaltoCond   = 1'b0;
        branch_ne   = 1'b0;
        oZero       = 1'b0;
        extSigno    = '0;
        jump        = 1'b0;
        jump_target = '0;
        jump_reg    = 1'b0;
        reg_target  = '0;
        call        = 1'b0;
        ret         = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic jumpTo(input logic [31:0] addr);
        jump_reg   = 1'b1;
        reg_target = addr;
        tick();
        clearIn();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clearIn();
        #12;
        nTests++;
        if (direinstrux !== 32'h0) begin
            $display("FAIL reset_pc: got %h exp %h", direinstrux, 32'h0); nFail++;
        end
        nTests++;
        if (pc_plus4 !== 32'h4) begin
            $display("FAIL reset_plus4: got %h exp %h", pc_plus4, 32'h4); nFail++;
        end
        nTests++;
        if ({ras_empty, ras_full, ras_top} !== {1'b1, 1'b0, 32'h0}) begin
            $display("FAIL reset_ras: got e=%b f=%b top=%h exp e=1 f=0 top=0",
                     ras_empty, ras_full, ras_top); nFail++;
        end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] expPc [3];
        expPc[0] = 32'h4; expPc[1] = 32'h8; expPc[2] = 32'hC;
        for (int i = 0; i < 3; i++) begin
            tick();
            nTests++;
            if (direinstrux !== expPc[i]) begin
                $display("FAIL seq_%0d: got %h exp %h", i, direinstrux, expPc[i]); nFail++;
            end
        end
    endtask

    task automatic test_branch();
        // beq taken: 0xC + (0xC000_0001 << 2 mod 2^32 = 4) = 0x10
        jumpTo(32'h8);
        SaltoCond = 1'b1; oZero = 1'b1; branch_ne = 1'b0; extSigno = 32'hC000_0001;
        tick(); clearIn();
        nTests++;
        if (direinstrux !== 32'h10) begin
            $display("FAIL br_beq_taken: got %h exp %h", direinstrux, 32'h10); nFail++;
        end
        // bne with zero set: not taken
        jumpTo(32'h8);
        SaltoCond = 1'b1; oZero = 1'b1; branch_ne = 1'b1; extSigno = 32'hC000_0001;
        tick(); clearIn();
        nTests++;
        if (direinstrux !== 32'hC) begin
            $display("FAIL br_bne_not_taken: got %h exp %h", direinstrux, 32'hC); nFail++;
        end
        // bne taken, negative offset: 0x24 + (-4 << 2) = 0x14
        jumpTo(32'h20);
        SaltoCond = 1'b1; oZero = 1'b0; branch_ne = 1'b1; extSigno = 32'hFFFF_FFFC;
        tick(); clearIn();
        nTests++;
        if (direinstrux !== 32'h14) begin
            $display("FAIL br_bne_taken_neg: got %h exp %h", direinstrux, 32'h14); nFail++;
        end
        // no SaltoCond: sequential regardless of flags
        oZero = 1'b1; extSigno = 32'h0000_0100;
        tick(); clearIn();
        nTests++;
        if (direinstrux !== 32'h18) begin
            $display("FAIL br_not_branch: got %h exp %h", direinstrux, 32'h18); nFail++;
        end
    endtask

    task automatic test_call_ret();
        jumpTo(32'h1000_0040);
        jump = 1'b1; jump_target = 26'h000_0100; call = 1'b1;
        tick(); clearIn();
        nTests++;
        if (direinstrux !== 32'h1000_0400) begin
            $display("FAIL jal_pc: got %h exp %h", direinstrux, 32'h1000_0400); nFail++;
        end
        nTests++;
        if (ras_top !== 32'h1000_0044 || ras_empty !== 1'b0) begin
            $display("FAIL jal_ras: got top=%h e=%b exp top=%h e=0",
                     ras_top, ras_empty, 32'h1000_0044); nFail++;
        end
        // ret without jump_reg is ignored
        ret = 1'b1;
        tick(); clearIn();
        nTests++;
        if (direinstrux !== 32'h1000_0404 || ras_top !== 32'h1000_0044) begin
            $display("FAIL ret_no_jr: got pc=%h top=%h exp pc=%h top=%h",
                     direinstrux, ras_top, 32'h1000_0404, 32'h1000_0044); nFail++;
        end
        jump_reg = 1'b1; ret = 1'b1; reg_target = 32'hDEAD_BEEC;
        tick(); clearIn();
        nTests++;
        if (direinstrux !== 32'h1000_0044 || ras_empty !== 1'b1) begin
            $display("FAIL jr_ra: got pc=%h e=%b exp pc=%h e=1",
                     direinstrux, ras_empty, 32'h1000_0044); nFail++;
        end
    endtask

    task automatic test_ras_wrap();
        logic [31:0] expPop [5];
        expPop[0] = 32'h114; expPop[1] = 32'h110; expPop[2] = 32'h10C;
        expPop[3] = 32'h108; expPop[4] = 32'h2000_0000;
        jumpTo(32'h100);
        for (int i = 0; i < 5; i++) begin
            call = 1'b1;
            tick();
        end
        clearIn();
        nTests++;
        if (ras_full !== 1'b1 || ras_top !== 32'h114 || direinstrux !== 32'h114) begin
            $display("FAIL ras_full: got f=%b top=%h pc=%h exp f=1 top=114 pc=114",
                     ras_full, ras_top, direinstrux); nFail++;
        end
        for (int i = 0; i < 5; i++) begin
            jump_reg = 1'b1; ret = 1'b1; reg_target = 32'h2000_0000;
            tick();
            nTests++;
            if (direinstrux !== expPop[i]) begin
                $display("FAIL ras_pop_%0d: got %h exp %h", i, direinstrux, expPop[i]); nFail++;
            end
        end
        clearIn();
        nTests++;
        if (ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_top !== 32'h0) begin
            $display("FAIL ras_drained: got e=%b f=%b top=%h exp e=1 f=0 top=0",
                     ras_empty, ras_full, ras_top); nFail++;
        end
    endtask

    task automatic test_call_and_pop();
        // PC 0x2000_0000: push 0x2000_0004
        call = 1'b1;
        tick(); clearIn();
        // PC 0x2000_0004: push 0x2000_0008 (two entries)
        call = 1'b1;
        tick(); clearIn();
        // PC 0x2000_0008: call + return -> PC = 0x2000_0008, top replaced by 0x2000_000C
        jump_reg = 1'b1; ret = 1'b1; call = 1'b1; reg_target = 32'h3000_0000;
        tick(); clearIn();
        nTests++;
        if (direinstrux !== 32'h2000_0008 || ras_top !== 32'h2000_000C) begin
            $display("FAIL call_pop: got pc=%h top=%h exp pc=%h top=%h",
                     direinstrux, ras_top, 32'h2000_0008, 32'h2000_000C); nFail++;
        end
        // count unchanged: two pops leave the stack empty, second returns 0x2000_0004
        jump_reg = 1'b1; ret = 1'b1;
        tick();
        tick(); clearIn();
        nTests++;
        if (direinstrux !== 32'h2000_0004 || ras_empty !== 1'b1) begin
            $display("FAIL call_pop_count: got pc=%h e=%b exp pc=%h e=1",
                     direinstrux, ras_empty, 32'h2000_0004); nFail++;
        end
        // jump and jump_reg together: jump_reg wins
        jump = 1'b1; jump_target = 26'h3FF_FFFF; jump_reg = 1'b1; reg_target = 32'h0000_0200;
        tick(); clearIn();
        nTests++;
        if (direinstrux !== 32'h200) begin
            $display("FAIL jr_over_j: got %h exp %h", direinstrux, 32'h200); nFail++;
        end
    endtask

    task automatic test_stall();
        call = 1'b1;
        tick(); clearIn();
        // PC 0x204, top 0x204
        stall = 1'b1; jump = 1'b1; jump_target = 26'h000_0040; call = 1'b1;
        tick();
        tick();
        clearIn();
        nTests++;
        if (direinstrux !== 32'h204 || ras_top !== 32'h204) begin
            $display("FAIL stall_hold: got pc=%h top=%h exp pc=204 top=204",
                     direinstrux, ras_top); nFail++;
        end
        tick();
        nTests++;
        if (direinstrux !== 32'h208) begin
            $display("FAIL stall_release: got %h exp %h", direinstrux, 32'h208); nFail++;
        end
        reset = 1'b1;
        #2;
        nTests++;
        if (direinstrux !== 32'h0 || ras_empty !== 1'b1) begin
            $display("FAIL async_reset: got pc=%h e=%b exp pc=0 e=1",
                     direinstrux, ras_empty); nFail++;
        end
        reset = 1'b0;
        tick();
        nTests++;
        if (direinstrux !== 32'h4) begin
            $display("FAIL post_reset: got %h exp %h", direinstrux, 32'h4); nFail++;
        end
    endtask

`ifdef PC_MISALIGN_EN
    task automatic test_misalign();
        jump_reg = 1'b1; reg_target = 32'h0000_0102;
        tick(); clearIn();
        nTests++;
        if (direinstrux !== 32'h80 || misalign !== 1'b1) begin
            $display("FAIL misalign_trap: got pc=%h m=%b exp pc=80 m=1",
                     direinstrux, misalign); nFail++;
        end
        tick();
        nTests++;
        if (direinstrux !== 32'h84 || misalign !== 1'b0) begin
            $display("FAIL misalign_clear: got pc=%h m=%b exp pc=84 m=0",
                     direinstrux, misalign); nFail++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_call_ret();
        test_ras_wrap();
        test_call_and_pop();
        test_stall();
`ifdef PC_MISALIGN_EN
        test_misalign();
`endif
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the single-cycle processor; successor to the plain `pc` block.
- Selects the next instruction address from:
  - sequential +4
  - conditional branch (beq/bne)
  - absolute jump
  - jump-register
- Adds a stall input and a small hardware return-address stack (RAS) for call/return prediction.
- Feeds `direinstrux` to instruction memory.

Parameters:
- W, 32: address width; legal values ≥ 32 (jump concatenation uses bits [W-1:28]).
- RESET_VECTOR, 32'h0000_0000: value loaded into the PC on reset, zero-extended to W.
- RAS_DEPTH, 4: return-address-stack entries; power of two, 2..16.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold PC and RAS this cycle
- SaltoCond  in  1  conditional-branch instruction
- branch_ne  in  1  0 = beq (taken when oZero=1); 1 = bne (taken when oZero=0)
- oZero  in  1  ALU zero flag
- extSigno  in  W  sign-extended branch offset, in words
- jump  in  1  absolute jump (j/jal)
- jump_target  in  26  instruction index field
- jump_reg  in  1  jump-register (jr/jalr)
- reg_target  in  W  register-file value for jump_reg
- call  in  1  push return address (jal/jalr)
- ret  in  1  jump_reg is a return (jr $ra); use RAS prediction
- direinstrux  out  W  current instruction address
- pc_plus4  out  W  direinstrux + 4, combinational
- ras_top  out  W  current RAS top entry; 0 when empty
- ras_empty  out  1  RAS holds 0 entries
- ras_full  out  1  RAS holds RAS_DEPTH entries

Behaviour:
- Reset (async, active-high): direinstrux=RESET_VECTOR, RAS count=0, RAS pointer=0, all RAS entries=0, ras_empty=1, ras_full=0. Reset asserted mid-operation clears state immediately, regardless of clk.
- Arithmetic is modulo 2^W.
  - branch_target = pc_plus4 + (extSigno << 2); the shift discards the upper 2 bits.
  - jump_addr = {pc_plus4[W-1:28], jump_target, 2'b00}.
- Taken = SaltoCond & (oZero ^ branch_ne).
- Next-PC priority, registered on the rising clk edge:
  1. stall=1: PC holds; RAS unchanged; all control inputs ignored.
  2. jump_reg=1: if ret=1 and RAS non-empty, next = ras_top; otherwise next = reg_target.
  3. jump=1: next = jump_addr.
  4. Taken: next = branch_target.
  5. Otherwise: next = pc_plus4.
- Latency: one cycle from inputs to direinstrux; pc_plus4 and ras_top are combinational from state.
- RAS (circular LIFO):
  - call=1 pushes pc_plus4. When full, the push overwrites the oldest entry and count stays at RAS_DEPTH (wrap-around).
  - ret=1 with jump_reg=1 pops when non-empty. Pop on an empty RAS is a no-op; the PC uses reg_target.
  - ret without jump_reg is ignored.
  - call and valid pop in the same cycle: top entry is replaced by pc_plus4; count unchanged.
  - call and pop on an empty RAS in the same cycle: plain push.
- Misprediction is not checked; the core guarantees $ra matches for well-nested code.
- jump and jump_reg both asserted: jump_reg wins (decoder error; no flag raised).

Optional Feature:
- Macro: PC_MISALIGN_EN.
- Enabled:
  - Extra parameter EXC_VECTOR (default 32'h0000_0080).
  - Extra output `misalign` (1 bit, registered, reset 0).
  - If the selected next PC has bits [1:0] ≠ 0, the PC loads EXC_VECTOR instead and misalign=1 for that cycle. The RAS still updates as normal.
- Disabled: no port, no parameter; the next PC is loaded unchecked.

Decomposition:
- Shared package `pc_pkg` holds:
  - next-PC select enum: SEL_SEQ, SEL_BR, SEL_J, SEL_JR, SEL_RAS, SEL_EXC
  - constant INSTR_BYTES=4
  - default RESET_VECTOR and EXC_VECTOR
- One sub-module: `ras_stack` (parametrised W and RAS_DEPTH). Contains the pointer, count and entry array; push/pop interface; exposes top/empty/full.

Test Plan:
- Reset then 3 free-running cycles → direinstrux = 0x0, 0x4, 0x8, 0xC.
- At PC=0x8: SaltoCond=1, oZero=1, branch_ne=0, extSigno=0xC000_0001 → next PC = 0x10. Repeat with branch_ne=1 → 0xC.
- At PC=0x1000_0040: jump=1, jump_target=0x000_0100, call=1 → PC = 0x1000_0400, ras_top = 0x1000_0044. Then jump_reg=1, ret=1, reg_target=0xDEAD_BEEC → PC = 0x1000_0044, ras_empty=1.
- Push 5 calls with RAS_DEPTH=4 → ras_full=1; 4 pops return the last 4 addresses in LIFO order; 5th pop falls back to reg_target.
- stall=1 for 2 cycles with jump=1 → PC and RAS unchanged. Assert reset mid-cycle → PC=RESET_VECTOR before the next edge.
- PC_MISALIGN_EN defined: jump_reg=1, reg_target=0x0000_0102 → PC = 0x80, misalign=1 for one cycle.
